// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side VGA timing recovery. Registers the sync,
// blank and colour inputs once, recovers active-pixel coordinates, measures
// the frame geometry, locks when the geometry repeats and captures the colour
// of one programmable probe pixel per frame.
module vga_sync_decoder #(
   parameter logic HS_ACTIVE_LOW = 1'b1,
   parameter logic VS_ACTIVE_LOW = 1'b1
) (
   input  logic        clk_vga,
   input  logic        rst,
   input  logic        VGA_HS,
   input  logic        VGA_VS,
   input  logic        VGA_BLANK_N,
   input  logic [7:0]  VGA_R,
   input  logic [7:0]  VGA_G,
   input  logic [7:0]  VGA_B,
   input  logic [11:0] probe_x,
   input  logic [11:0] probe_y,
   output logic [11:0] x,
   output logic [11:0] y,
   output logic        pix_valid,
   output logic        frame_start,
   output logic [11:0] h_total,
   output logic [11:0] h_active,
   output logic [11:0] v_total,
   output logic [11:0] v_active,
   output logic        locked,
   output logic        timing_err,
   output logic [23:0] probe_rgb,
   output logic        probe_valid
);

   localparam logic [1:0] SEARCH  = 2'd0;
   localparam logic [1:0] MEASURE = 2'd1;
   localparam logic [1:0] CHECK   = 2'd2;
   localparam logic [1:0] LOCKED  = 2'd3;
   localparam logic [11:0] SAT    = 12'hFFF;

   // Increment that sticks at the top of the 12-bit range.
   function automatic logic [11:0] satInc(input logic [11:0] v);
      return (v == SAT) ? v : v + 12'd1;
   endfunction

   logic        r_hs, r_vs, r_blank, r_hsD, r_vsD;
   logic [23:0] r_rgb;
   logic [11:0] r_hc, r_ax, r_vc, r_ay;
   logic [11:0] r_candHTot, r_candHAct;
   logic [1:0]  r_state;
   logic [11:0] r_hTotal, r_hActive, r_vTotal, r_vActive;
   logic        r_locked, r_timingErr;
   logic [11:0] r_x, r_y, r_probeX, r_probeY;
   logic        r_pixValid, r_frameStart, r_probeDone, r_probeValid;
   logic [23:0] r_probeRgb;

   logic        w_hsEdge, w_vsEdge, w_lineHadAct;
   logic [11:0] w_hcNext, w_axBase, w_axNext, w_vcH, w_ayH, w_vcNext, w_ayNext;
   logic [11:0] w_lineTot, w_curHTot, w_curHAct, w_curVTot, w_curVAct;
   logic        w_hMis, w_vMis, w_frameMis, w_sat, w_probeHit;

   // Edges and counter next-values; the horizontal update is folded in
   // before the vertical restart so a coincident HS/VS edge counts its line.
   assign w_hsEdge     = r_hs & ~r_hsD;
   assign w_vsEdge     = r_vs & ~r_vsD;
   assign w_lineHadAct = (r_ax != 12'd0);
   assign w_hcNext     = w_hsEdge ? 12'd0 : satInc(r_hc);
   assign w_axBase     = w_hsEdge ? 12'd0 : r_ax;
   assign w_axNext     = r_blank ? satInc(w_axBase) : w_axBase;
   assign w_vcH        = w_hsEdge ? satInc(r_vc) : r_vc;
   assign w_ayH        = (w_hsEdge && w_lineHadAct) ? satInc(r_ay) : r_ay;
   assign w_vcNext     = w_vsEdge ? 12'd0 : w_vcH;
   assign w_ayNext     = w_vsEdge ? 12'd0 : w_ayH;
   assign w_lineTot    = satInc(r_hc);
   assign w_curHTot    = w_hsEdge ? w_lineTot : r_candHTot;
   assign w_curHAct    = (w_hsEdge && w_lineHadAct) ? r_ax : r_candHAct;
   assign w_curVTot    = satInc(r_vc);
   assign w_curVAct    = w_ayH;
   assign w_hMis       = w_hsEdge && ((w_lineTot != r_hTotal) ||
                         (w_lineHadAct && (r_ax != r_hActive)));
   assign w_vMis       = (w_curVTot != r_vTotal) || (w_curVAct != r_vActive);
   assign w_frameMis   = w_vMis || (w_curHTot != r_hTotal) || (w_curHAct != r_hActive);
   assign w_sat        = ((w_hcNext == SAT) && (r_hc != SAT)) ||
                         ((w_axNext == SAT) && (r_ax != SAT)) ||
                         ((w_vcNext == SAT) && (r_vc != SAT)) ||
                         ((w_ayNext == SAT) && (r_ay != SAT));
   assign w_probeHit   = r_blank && r_locked && !r_probeDone &&
                         (w_axBase == r_probeX) && (w_ayNext == r_probeY);

   // Input stage: register everything once, normalise sync polarity, keep
   // the previous sample for edge detection.
   always_ff @(posedge clk_vga or negedge rst) begin
      if (!rst) begin
         r_hs <= 1'b0; r_vs <= 1'b0; r_blank <= 1'b0;
         r_hsD <= 1'b0; r_vsD <= 1'b0; r_rgb <= 24'd0;
      end else begin
         r_hs    <= HS_ACTIVE_LOW ? ~VGA_HS : VGA_HS;
         r_vs    <= VS_ACTIVE_LOW ? ~VGA_VS : VGA_VS;
         r_blank <= VGA_BLANK_N;
         r_rgb   <= {VGA_R, VGA_G, VGA_B};
         r_hsD   <= r_hs;
         r_vsD   <= r_vs;
      end
   end

   // Position counters plus the most recent line's length and active width.
   always_ff @(posedge clk_vga or negedge rst) begin
      if (!rst) begin
         r_hc <= 12'd0; r_ax <= 12'd0; r_vc <= 12'd0; r_ay <= 12'd0;
         r_candHTot <= 12'd0; r_candHAct <= 12'd0;
      end else begin
         r_hc       <= w_hcNext;
         r_ax       <= w_axNext;
         r_vc       <= w_vcNext;
         r_ay       <= w_ayNext;
         r_candHTot <= w_curHTot;
         r_candHAct <= w_curHAct;
      end
   end

   // Lock FSM and measurement outputs; saturation overrides everything.
   always_ff @(posedge clk_vga or negedge rst) begin
      if (!rst) begin
         r_state <= SEARCH; r_locked <= 1'b0; r_timingErr <= 1'b0;
         r_hTotal <= 12'd0; r_hActive <= 12'd0;
         r_vTotal <= 12'd0; r_vActive <= 12'd0;
      end else begin
         r_timingErr <= 1'b0;
         case (r_state)
            SEARCH: if (w_vsEdge) r_state <= MEASURE;
            MEASURE: if (w_vsEdge) begin
               r_hTotal <= w_curHTot; r_hActive <= w_curHAct;
               r_vTotal <= w_curVTot; r_vActive <= w_curVAct;
               r_state  <= CHECK;
            end
            CHECK: if (w_vsEdge) begin
               if (w_frameMis) begin
                  r_hTotal <= w_curHTot; r_hActive <= w_curHAct;
                  r_vTotal <= w_curVTot; r_vActive <= w_curVAct;
                  r_timingErr <= 1'b1;
               end else begin
                  r_state  <= LOCKED;
                  r_locked <= 1'b1;
               end
            end
            LOCKED: begin
               if (w_hMis) begin
                  r_hTotal <= w_lineTot;
                  if (w_lineHadAct) r_hActive <= r_ax;
                  r_timingErr <= 1'b1; r_locked <= 1'b0; r_state <= CHECK;
               end
               if (w_vsEdge && w_vMis) begin
                  r_vTotal <= w_curVTot; r_vActive <= w_curVAct;
                  r_timingErr <= 1'b1; r_locked <= 1'b0; r_state <= CHECK;
               end
            end
            default: r_state <= SEARCH;
         endcase
         if (w_sat) begin
            r_state <= SEARCH; r_locked <= 1'b0; r_timingErr <= 1'b1;
         end
      end
   end

   // Coordinates, frame pulse and one-shot probe capture.
   always_ff @(posedge clk_vga or negedge rst) begin
      if (!rst) begin
         r_x <= 12'd0; r_y <= 12'd0; r_pixValid <= 1'b0; r_frameStart <= 1'b0;
         r_probeX <= 12'd0; r_probeY <= 12'd0; r_probeDone <= 1'b0;
         r_probeRgb <= 24'd0; r_probeValid <= 1'b0;
      end else begin
         r_pixValid   <= r_blank;
         r_frameStart <= w_vsEdge;
         r_probeValid <= w_probeHit;
         if (r_blank) begin
            r_x <= w_axBase;
            r_y <= w_ayNext;
         end
         if (w_vsEdge) begin
            r_probeX    <= probe_x;
            r_probeY    <= probe_y;
            r_probeDone <= 1'b0;
         end else if (w_probeHit) begin
            r_probeDone <= 1'b1;
         end
         if (w_probeHit) r_probeRgb <= r_rgb;
      end
   end

   assign x           = r_x;
   assign y           = r_y;
   assign pix_valid   = r_pixValid;
   assign frame_start = r_frameStart;
   assign h_total     = r_hTotal;
   assign h_active    = r_hActive;
   assign v_total     = r_vTotal;
   assign v_active    = r_vActive;
   assign locked      = r_locked;
   assign timing_err  = r_timingErr;
   assign probe_rgb   = r_probeRgb;
   assign probe_valid = r_probeValid;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a reduced video mode: 16-clock lines
// (HS 2, back porch 2, active 10, front porch 2) and 12-line frames
// (VS 1, back porch 1, active 8, front porch 2).
module tb_vga_sync_decoder;

   logic        clk_vga = 1'b0;
   logic        rst;
   logic        VGA_HS, VGA_VS, VGA_BLANK_N;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic [11:0] probe_x, probe_y;
   logic [11:0] x, y, h_total, h_active, v_total, v_active;
   logic        pix_valid, frame_start, locked, timing_err, probe_valid;
   logic [23:0] probe_rgb;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int fsTotal = 0, errTotal = 0, pvTotal = 0, probeTotal = 0;
   logic        lockedAtFs [0:63];
   logic [23:0] lastProbeRgb;
   logic [11:0] firstX, firstY, lastX, lastY;
   int          firstPvCyc = 0;
   bit          awaitFirst = 0;

   int paintX = -1, paintY = -1;
   int blankRiseCyc = 0;

   wire [99:0] allOut = {x, y, pix_valid, frame_start, h_total, h_active,
                         v_total, v_active, locked, timing_err, probe_rgb, probe_valid};

   vga_sync_decoder dut (
      .clk_vga(clk_vga), .rst(rst),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .probe_x(probe_x), .probe_y(probe_y),
      .x(x), .y(y), .pix_valid(pix_valid), .frame_start(frame_start),
      .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
      .locked(locked), .timing_err(timing_err),
      .probe_rgb(probe_rgb), .probe_valid(probe_valid)
   );

   // Pixel clock.
   always #5 clk_vga = ~clk_vga;

   // Free-running cycle counter used for latency measurement.
   always @(posedge clk_vga) cyc <= cyc + 1;

   // Observer: accumulates event counts on the falling edge, away from the
   // edge where the DUT updates.
   always @(negedge clk_vga) begin
      if (frame_start) begin
         lockedAtFs[fsTotal % 64] = locked;
         fsTotal++;
         awaitFirst = 1;
      end
      if (timing_err) errTotal++;
      if (pix_valid) begin
         pvTotal++;
         lastX = x;
         lastY = y;
         if (awaitFirst) begin
            firstPvCyc = cyc;
            firstX = x;
            firstY = y;
            awaitFirst = 0;
         end
      end
      if (probe_valid) begin
         probeTotal++;
         lastProbeRgb = probe_rgb;
      end
   end

   // Drive one pixel clock worth of inputs (sync flags given active-high).
   task automatic tick(input bit hsA, input bit vsA, input bit blank, input logic [23:0] rgb);
      VGA_HS = ~hsA;
      VGA_VS = ~vsA;
      VGA_BLANK_N = blank;
      {VGA_R, VGA_G, VGA_B} = rgb;
      @(posedge clk_vga);
      #1;
   endtask

   // Drive a frame from firstLine onwards, optionally without VS, with one
   // line stretched by a clock, stopping early after maxClk clocks.
   task automatic driveFrame(input bit vsEn, input int glitchLine, input int firstLine, input int maxClk);
      int n;
      bit first;
      int len;
      bit blank;
      logic [23:0] rgb;
      n = 0;
      first = 1;
      for (int ln = firstLine; ln < 12; ln++) begin
         len = (ln == glitchLine) ? 17 : 16;
         for (int c = 0; c < len; c++) begin
            if (n >= maxClk) return;
            blank = (ln >= 2 && ln < 10 && c >= 4 && c < 14);
            rgb = (blank && (c - 4) == paintX && (ln - 2) == paintY) ? 24'hFF6000 : 24'h000000;
            if (blank && first) begin
               blankRiseCyc = cyc;
               first = 0;
            end
            tick(c < 2, vsEn && ln == 0, blank, rgb);
            n++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      probe_x = 12'd0;
      probe_y = 12'd0;
      VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_N = 1'b0;
      VGA_R = 8'd0; VGA_G = 8'd0; VGA_B = 8'd0;
      repeat (3) @(posedge clk_vga);
      #1;
      checks++;
      if (allOut !== 100'd0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got %h expected 0", allOut);
      end
      rst = 1'b1;
      repeat (5) tick(0, 0, 0, 24'd0);
      checks++;
      if (allOut !== 100'd0) begin
         failures++;
         $display("[TB] FAIL idle_outputs: got %h expected 0", allOut);
      end
   endtask

   task automatic test_lock();
      int fsB, eB;
      fsB = fsTotal;
      eB = errTotal;
      repeat (3) driveFrame(1, -1, 0, 1000);
      checks++;
      if (fsTotal - fsB != 3) begin
         failures++;
         $display("[TB] FAIL lock_fs_count: got %0d expected 3", fsTotal - fsB);
      end
      checks++;
      if (lockedAtFs[fsB % 64] !== 1'b0 || lockedAtFs[(fsB + 1) % 64] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL lock_early: got %b%b expected 00", lockedAtFs[fsB % 64], lockedAtFs[(fsB + 1) % 64]);
      end
      checks++;
      if (lockedAtFs[(fsB + 2) % 64] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL lock_third_fs: got %b expected 1", lockedAtFs[(fsB + 2) % 64]);
      end
      checks++;
      if (h_total !== 12'd16) begin
         failures++;
         $display("[TB] FAIL lock_h_total: got %0d expected 16", h_total);
      end
      checks++;
      if (h_active !== 12'd10) begin
         failures++;
         $display("[TB] FAIL lock_h_active: got %0d expected 10", h_active);
      end
      checks++;
      if (v_total !== 12'd12) begin
         failures++;
         $display("[TB] FAIL lock_v_total: got %0d expected 12", v_total);
      end
      checks++;
      if (v_active !== 12'd8) begin
         failures++;
         $display("[TB] FAIL lock_v_active: got %0d expected 8", v_active);
      end
      checks++;
      if (errTotal != eB) begin
         failures++;
         $display("[TB] FAIL lock_no_err: got %0d expected 0", errTotal - eB);
      end
   endtask

   task automatic test_coordinates();
      int pvB;
      pvB = pvTotal;
      driveFrame(1, -1, 0, 1000);
      checks++;
      if (pvTotal - pvB != 80) begin
         failures++;
         $display("[TB] FAIL coord_pv_count: got %0d expected 80", pvTotal - pvB);
      end
      checks++;
      if (firstX !== 12'd0 || firstY !== 12'd0) begin
         failures++;
         $display("[TB] FAIL coord_first: got (%0d,%0d) expected (0,0)", firstX, firstY);
      end
      checks++;
      if (firstPvCyc - blankRiseCyc != 2) begin
         failures++;
         $display("[TB] FAIL coord_latency: got %0d expected 2", firstPvCyc - blankRiseCyc);
      end
      checks++;
      if (lastX !== 12'd9 || lastY !== 12'd7) begin
         failures++;
         $display("[TB] FAIL coord_last: got (%0d,%0d) expected (9,7)", lastX, lastY);
      end
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("[TB] FAIL coord_locked: got %b expected 1", locked);
      end
   endtask

   task automatic test_probe();
      int prB;
      probe_x = 12'd5; probe_y = 12'd3;
      paintX = 5; paintY = 3;
      prB = probeTotal;
      repeat (2) driveFrame(1, -1, 0, 1000);
      checks++;
      if (probeTotal - prB != 2) begin
         failures++;
         $display("[TB] FAIL probe_count: got %0d expected 2", probeTotal - prB);
      end
      checks++;
      if (lastProbeRgb !== 24'hFF6000) begin
         failures++;
         $display("[TB] FAIL probe_rgb: got %h expected ff6000", lastProbeRgb);
      end
      probe_x = 12'd10; probe_y = 12'd3;
      prB = probeTotal;
      driveFrame(1, -1, 0, 1000);
      checks++;
      if (probeTotal != prB) begin
         failures++;
         $display("[TB] FAIL probe_x_edge: got %0d expected 0", probeTotal - prB);
      end
      probe_x = 12'd700; probe_y = 12'd10;
      prB = probeTotal;
      driveFrame(1, -1, 0, 1000);
      checks++;
      if (probeTotal != prB) begin
         failures++;
         $display("[TB] FAIL probe_far: got %0d expected 0", probeTotal - prB);
      end
   endtask

   task automatic test_line_glitch();
      int eB, prB, fsB;
      probe_x = 12'd5; probe_y = 12'd6;
      paintX = 5; paintY = 6;
      eB = errTotal; prB = probeTotal;
      driveFrame(1, 4, 0, 1000);
      checks++;
      if (errTotal - eB != 1) begin
         failures++;
         $display("[TB] FAIL glitch_err: got %0d expected 1", errTotal - eB);
      end
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("[TB] FAIL glitch_unlock: got %b expected 0", locked);
      end
      checks++;
      if (h_total !== 12'd17) begin
         failures++;
         $display("[TB] FAIL glitch_h_total: got %0d expected 17", h_total);
      end
      checks++;
      if (probeTotal != prB) begin
         failures++;
         $display("[TB] FAIL glitch_probe_gated: got %0d expected 0", probeTotal - prB);
      end
      eB = errTotal; fsB = fsTotal;
      driveFrame(1, -1, 0, 1000);
      checks++;
      if (errTotal - eB != 1 || h_total !== 12'd16) begin
         failures++;
         $display("[TB] FAIL glitch_recheck: got err=%0d h_total=%0d expected err=1 h_total=16", errTotal - eB, h_total);
      end
      checks++;
      if (lockedAtFs[fsB % 64] !== 1'b0 || locked !== 1'b0) begin
         failures++;
         $display("[TB] FAIL glitch_still_unlocked: got %b expected 0", locked);
      end
      eB = errTotal; prB = probeTotal;
      driveFrame(1, -1, 0, 1000);
      checks++;
      if (locked !== 1'b1 || errTotal != eB) begin
         failures++;
         $display("[TB] FAIL glitch_relock: got locked=%b err=%0d expected locked=1 err=0", locked, errTotal - eB);
      end
      checks++;
      if (probeTotal - prB != 1) begin
         failures++;
         $display("[TB] FAIL glitch_probe_after_lock: got %0d expected 1", probeTotal - prB);
      end
   endtask

   task automatic test_missing_vs();
      int eB, fsB;
      eB = errTotal; fsB = fsTotal;
      repeat (342) driveFrame(0, -1, 0, 1000);
      checks++;
      if (errTotal - eB != 1) begin
         failures++;
         $display("[TB] FAIL novs_err_once: got %0d expected 1", errTotal - eB);
      end
      checks++;
      if (locked !== 1'b0 || fsTotal != fsB) begin
         failures++;
         $display("[TB] FAIL novs_unlock: got locked=%b fs=%0d expected locked=0 fs=0", locked, fsTotal - fsB);
      end
      checks++;
      if (v_total !== 12'd12) begin
         failures++;
         $display("[TB] FAIL novs_v_total_held: got %0d expected 12", v_total);
      end
      fsB = fsTotal;
      repeat (3) driveFrame(1, -1, 0, 1000);
      checks++;
      if (lockedAtFs[(fsB + 1) % 64] !== 1'b0 || lockedAtFs[(fsB + 2) % 64] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL novs_relock_from_search: got %b%b expected 01", lockedAtFs[(fsB + 1) % 64], lockedAtFs[(fsB + 2) % 64]);
      end
   endtask

   task automatic test_reset_mid();
      int fsB, eB;
      driveFrame(1, -1, 0, 16 * 5 + 7);
      checks++;
      if (locked !== 1'b1 || pix_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midreset_pre: got locked=%b pv=%b expected 1 1", locked, pix_valid);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (allOut !== 100'd0) begin
         failures++;
         $display("[TB] FAIL midreset_clear: got %h expected 0", allOut);
      end
      @(posedge clk_vga);
      @(posedge clk_vga);
      #1;
      rst = 1'b1;
      fsB = fsTotal; eB = errTotal;
      driveFrame(1, -1, 5, 1000);
      repeat (3) driveFrame(1, -1, 0, 1000);
      checks++;
      if (fsTotal - fsB != 3) begin
         failures++;
         $display("[TB] FAIL midreset_fs_count: got %0d expected 3", fsTotal - fsB);
      end
      checks++;
      if (lockedAtFs[(fsB + 1) % 64] !== 1'b0 || lockedAtFs[(fsB + 2) % 64] !== 1'b1 || errTotal != eB) begin
         failures++;
         $display("[TB] FAIL midreset_relock: got %b%b err=%0d expected 01 err=0", lockedAtFs[(fsB + 1) % 64], lockedAtFs[(fsB + 2) % 64], errTotal - eB);
      end
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_lock();
      test_coordinates();
      test_probe();
      test_line_glitch();
      test_missing_vs();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
